// File: rtl/inst_fetch_queue_pkg.sv
// Shared packet layout for the instruction fetch queue: {pc, instr, adel}.
// Decode-side unpacking uses the same offsets.
package inst_fetch_queue_pkg;

    localparam int IFQ_ADEL_OFF  = 0;
    localparam int IFQ_INSTR_OFF = 1;

    function automatic int ifq_pkt_w(input int pc_w, input int data_w);
        return pc_w + data_w + 1;
    endfunction

    function automatic int ifq_pc_off(input int data_w);
        return data_w + 1;
    endfunction

endpackage

// File: rtl/inst_fetch_queue_ptr.sv
// Wrap-bit pointer: the MSB toggles each time the index wraps DEPTH-1 -> 0.
// It has an async reset, an increment enable and a synchronous clear.
module ifq_ptr #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    logic [W-1:0] ptr_d;
    logic [W-1:0] ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue between the I-SRAM fetch stage and Decode.
// It supports flush on redirect and an optional same-cycle bypass into an empty queue.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int DATA_W    = 32,
    parameter int PC_W      = 32,
    parameter int BYPASS    = 0,
    parameter int AFULL_LVL = DEPTH - 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     enq_valid,
    input  logic [PC_W-1:0]          enq_pc,
    input  logic [DATA_W-1:0]        enq_instr,
    input  logic                     enq_adel,
    output logic                     enq_ready,
    output logic                     deq_valid,
    output logic [PC_W-1:0]          deq_pc,
    output logic [DATA_W-1:0]        deq_instr,
    output logic                     deq_adel,
    input  logic                     deq_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     afull
);

    localparam int   IDX_W  = $clog2(DEPTH);
    localparam int   PTR_W  = IDX_W + 1;
    localparam int   PKT_W  = ifq_pkt_w(PC_W, DATA_W);
    localparam int   PC_OFF = ifq_pc_off(DATA_W);
    localparam logic BYP    = (BYPASS != 0);

    logic [PKT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PKT_W-1:0] enq_pkt;
    logic [PKT_W-1:0] deq_pkt;
    logic             empty;
    logic             full;
    logic             enq_fire;
    logic             deq_fire;
    logic             pass_thru;
    logic             wr_en;
    logic             rd_en;

    // Handshake: a transfer happens on a side when valid & ready are both high
    // at posedge clk; enq_ready never looks at deq_ready and flush kills both sides.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                       (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);
    assign enq_ready = ~full;
    assign deq_valid = (~empty | (BYP & enq_valid)) & ~flush;
    assign enq_fire  = enq_valid & enq_ready & ~flush;
    assign deq_fire  = deq_valid & deq_ready;

    // A bypassed packet is consumed straight from the inputs and never stored.
    assign pass_thru = BYP & empty & enq_fire & deq_fire;
    assign wr_en     = enq_fire & ~pass_thru;
    assign rd_en     = deq_fire & ~pass_thru;

    ifq_ptr #(.W(PTR_W)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (wr_en),
        .ptr (wr_ptr)
    );

    ifq_ptr #(.W(PTR_W)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (rd_en),
        .ptr (rd_ptr)
    );

    assign enq_pkt = {enq_pc, enq_instr, enq_adel};

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr[IDX_W-1:0]] <= enq_pkt;
        end
    end

    always_comb begin
        deq_pkt = '0;
        if (!empty) begin
            deq_pkt = mem_q[rd_ptr[IDX_W-1:0]];
        end else if (BYP) begin
            deq_pkt = enq_pkt;
        end
    end

    assign deq_pc    = deq_pkt[PC_OFF +: PC_W];
    assign deq_instr = deq_pkt[IFQ_INSTR_OFF +: DATA_W];
    assign deq_adel  = deq_pkt[IFQ_ADEL_OFF];

    assign count = wr_ptr - rd_ptr;
    assign afull = (count >= PTR_W'(AFULL_LVL));

endmodule
